alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 28 ++
 rtl/alu_pipe_mul.sv | 62 ++++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// alu_pipe_pkg : shared opcode/state types and result-width derivation
// Rev 1.0
// ============================================================================
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int out_w(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// ============================================================================
// alu_pipe_mul : iterative unsigned shift-add multiplier, one step per cycle
// Rev 1.0
// ============================================================================
module alu_pipe_mul
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int OUT_W = out_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [OUT_W-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             running;

    // done marks the cycle whose edge performs the final partial-product step
    assign done    = running && (count == CW'(WIDTH - 1));
    assign product = acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= OUT_W'(a);
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                count   <= '0;
                running <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : handshaked ALU (ADD/SUB/AND/OR/XOR inline, optional iterative MUL)
// Optional feature macro: ALU_PIPE_MUL_EN enables the shift-add multiplier.
// Rev 1.0
// ============================================================================
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int OUT_W = out_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_i_valid,
    output logic             io_i_ready,
    input  logic [2:0]       io_i_op,
    input  logic [WIDTH-1:0] io_i_A,
    input  logic [WIDTH-1:0] io_i_B,
    output logic             io_o_valid,
    input  logic             io_o_ready,
    output logic [OUT_W-1:0] io_o_W,
    output logic             io_o_err
);

    state_e           state;
    state_e           next_state;
    logic             accept;
    logic             is_mul;
    logic [OUT_W-1:0] alu_res;
    logic             alu_err;
    logic [OUT_W-1:0] result;

`ifdef ALU_PIPE_MUL_EN
    logic             mul_done;
    logic [OUT_W-1:0] mul_product;
    logic             sel_mul;

    assign is_mul = (io_i_op == OP_MUL);

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (io_i_A),
        .b       (io_i_B),
        .done    (mul_done),
        .product (mul_product)
    );

    // multiplier keeps its product stable after finishing, so it is muxed out directly
    assign io_o_W = sel_mul ? mul_product : result;
`else
    assign is_mul = 1'b0;
    assign io_o_W = result;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        io_i_ready = 1'b0;
        io_o_valid = 1'b0;
        case (state)
            IDLE: io_i_ready = 1'b1;
            DONE: begin
                io_o_valid = 1'b1;
                io_i_ready = io_o_ready;
            end
            default: ;
        endcase
        accept = io_i_valid && io_i_ready;
        if (accept) begin
            next_state = is_mul ? BUSY : DONE;
        end else begin
            case (state)
`ifdef ALU_PIPE_MUL_EN
                BUSY: if (mul_done) next_state = DONE;
`else
                BUSY: next_state = IDLE;
`endif
                DONE: if (io_o_ready) next_state = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_e'(io_i_op))
            OP_ADD: alu_res = OUT_W'(io_i_A) + OUT_W'(io_i_B);
            OP_SUB: alu_res = OUT_W'(io_i_A) - OUT_W'(io_i_B);
            OP_AND: alu_res = OUT_W'(io_i_A & io_i_B);
            OP_OR:  alu_res = OUT_W'(io_i_A | io_i_B);
            OP_XOR: alu_res = OUT_W'(io_i_A ^ io_i_B);
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result   <= '0;
            io_o_err <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            sel_mul  <= 1'b0;
`endif
        end else if (accept) begin
            result   <= alu_res;
            io_o_err <= alu_err;
`ifdef ALU_PIPE_MUL_EN
            sel_mul  <= is_mul;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : directed stimulus with queue scoreboard and decoupled monitor
// Rev 1.0
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 16;
    localparam int OUT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_i_valid = 1'b0;
    logic             io_i_ready;
    logic [2:0]       io_i_op = 3'd0;
    logic [WIDTH-1:0] io_i_A = '0;
    logic [WIDTH-1:0] io_i_B = '0;
    logic             io_o_valid;
    logic             io_o_ready = 1'b1;
    logic [OUT_W-1:0] io_o_W;
    logic             io_o_err;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_i_valid (io_i_valid),
        .io_i_ready (io_i_ready),
        .io_i_op    (io_i_op),
        .io_i_A     (io_i_A),
        .io_i_B     (io_i_B),
        .io_o_valid (io_o_valid),
        .io_o_ready (io_o_ready),
        .io_o_W     (io_o_W),
        .io_o_err   (io_o_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_W-1:0] w;
        logic             err;
        int               acc_cyc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   head_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: first appearance checks latency, the transfer checks data
    always @(negedge clock) begin
        if (reset && io_o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got W=%0h err=%0b expected no result", io_o_W, io_o_err);
            end else begin
                if (!head_seen) begin
                    check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    head_seen = 1'b1;
                end
                if (io_o_ready) begin
                    check("result_W", 64'(io_o_W), 64'(sb[0].w));
                    check("result_err", 64'(io_o_err), 64'(sb[0].err));
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] w, input logic err, input int lat);
        int n;
        exp_t e;
        n = 0;
        io_i_valid = 1'b1;
        io_i_op    = op;
        io_i_A     = a;
        io_i_B     = b;
        @(negedge clock);
        while (!io_i_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!io_i_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end else begin
            e.w = w; e.err = err; e.acc_cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        io_i_A     = ~a;
        io_i_B     = ~b;
        io_i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    logic [15:0] b2b_a [6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'hABCD, 16'h00FF};
    logic [15:0] b2b_b [6] = '{16'h0002, 16'hFFFF, 16'h0000, 16'h0001, 16'h1111, 16'hFF01};
    logic [31:0] b2b_w [6] = '{32'h3, 32'h1FFFE, 32'h0, 32'h8000, 32'hBCDE, 32'h10000};

    initial begin
        #2;
        check("reset_valid", 64'(io_o_valid), 64'd0);
        check("reset_W", 64'(io_o_W), 64'd0);
        check("reset_err", 64'(io_o_err), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_reset", 64'(io_i_ready), 64'd1);

        send(3'd0, 16'hFFFF, 16'h0001, 32'h00010000, 1'b0, 1); wait_idle();
        send(3'd1, 16'd100,  16'd200,  32'hFFFFFF9C, 1'b0, 1); wait_idle();
        send(3'd4, 16'hF0F0, 16'hFFFF, 32'h00000F0F, 1'b0, 1); wait_idle();
        send(3'd2, 16'hF0F0, 16'h3C3C, 32'h00003030, 1'b0, 1); wait_idle();
        send(3'd3, 16'hF0F0, 16'h0F00, 32'h0000FFF0, 1'b0, 1); wait_idle();
        send(3'd1, 16'h0005, 16'h0005, 32'h00000000, 1'b0, 1); wait_idle();
        send(3'd1, 16'h0000, 16'h0001, 32'hFFFFFFFF, 1'b0, 1); wait_idle();
        send(3'd6, 16'h1234, 16'h5678, 32'h00000000, 1'b1, 1); wait_idle();

`ifdef ALU_PIPE_MUL_EN
        send(3'd5, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, WIDTH + 1);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clock);
            check("busy_ready", 64'(io_i_ready), 64'd0);
        end
        wait_idle();
        send(3'd5, 16'h0003, 16'h0005, 32'h0000000F, 1'b0, WIDTH + 1); wait_idle();
        send(3'd5, 16'h8000, 16'h0002, 32'h00010000, 1'b0, WIDTH + 1); wait_idle();
`else
        send(3'd5, 16'hFFFF, 16'hFFFF, 32'h00000000, 1'b1, 1); wait_idle();
`endif

        for (int i = 0; i < 6; i++) begin
            send(3'd0, b2b_a[i], b2b_b[i], b2b_w[i], 1'b0, 1);
        end
        wait_idle();

        // stalled illegal result; a pending ADD must not be captured meanwhile
        io_o_ready = 1'b0;
        send(3'd7, 16'h0001, 16'h0002, 32'h00000000, 1'b1, 1);
        io_i_valid = 1'b1;
        io_i_op    = 3'd0;
        io_i_A     = 16'h0001;
        io_i_B     = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_valid", 64'(io_o_valid), 64'd1);
            check("stall_W", 64'(io_o_W), 64'd0);
            check("stall_err", 64'(io_o_err), 64'd1);
            check("stall_ready", 64'(io_i_ready), 64'd0);
        end
        @(posedge clock);
        #1;
        io_o_ready = 1'b1;
        send(3'd0, 16'h0001, 16'h0002, 32'h00000003, 1'b0, 1);
        wait_idle();

`ifdef ALU_PIPE_MUL_EN
        send(3'd5, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, WIDTH + 1);
        repeat (7) @(posedge clock);
`else
        io_o_ready = 1'b0;
        send(3'd7, 16'h0001, 16'h0001, 32'h00000000, 1'b1, 1);
        repeat (2) @(posedge clock);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("abort_valid", 64'(io_o_valid), 64'd0);
        check("abort_W", 64'(io_o_W), 64'd0);
        check("abort_err", 64'(io_o_err), 64'd0);
        sb.delete();
        head_seen  = 1'b0;
        io_o_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_abort", 64'(io_i_ready), 64'd1);
        send(3'd0, 16'd3, 16'd4, 32'd7, 1'b0, 1);
        wait_idle();
        repeat (30) @(negedge clock);
        check("final_queue", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
